axilite_read_addr: RTL and testbench
====================================

AXILITE_READ_ADDR -- requirements
Module: axilite_read_addr

Interface
REQ-001 The block SHALL have parameter ADDR_SIZE, default 32: width of araddr and addr.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255: number of HOLD cycles before timeout; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port araddr  input  ADDR_SIZE  AXI-Lite read address.
REQ-006 The block SHALL have port arprot  input  3  AXI-Lite protection bits; captured, not interpreted.
REQ-007 The block SHALL have port arvalid  input  1  master address valid.
REQ-008 The block SHALL have port arready  output  1  slave address ready; registered.
REQ-009 The block SHALL have port addr  output  ADDR_SIZE  latched address to the read-data stage.
REQ-010 The block SHALL have port prot  output  3  latched arprot.
REQ-011 The block SHALL have port addr_good  output  1  latched address valid to the read-data stage.
REQ-012 The block SHALL have port addr_misaligned  output  1  latched address not DATA_WIDTH/8-aligned (addr[1:0] != 0).
REQ-013 The block SHALL have port deassert_addr  input  1  read-data stage has consumed addr.
REQ-014 The block SHALL have port timeout  output  1  one-cycle pulse on HOLD timeout (macro-gated, see Configuration).

Function
REQ-015 The block SHALL implement two states: IDLE (arready=1, addr_good=0) and HOLD (arready=0, addr_good=1).
REQ-016 IDLE -> HOLD: on a clock edge with arvalid=1 and arready=1; the same edge SHALL load addr<=araddr, prot<=arprot, addr_misaligned<=(araddr[1:0]!=0), addr_good<=1, arready<=0.
REQ-017 HOLD -> IDLE: on a clock edge with deassert_addr=1; the same edge SHALL set addr_good<=0 and arready<=1.
REQ-018 Handshake-to-addr_good latency SHALL be exactly one cycle; deassert_addr-to-arready latency SHALL be exactly one cycle.
REQ-019 addr, prot and addr_misaligned SHALL be stable throughout HOLD and SHALL retain their last value in IDLE.
REQ-020 At most one address SHALL be outstanding; arvalid in HOLD SHALL be ignored because arready=0.
REQ-021 deassert_addr in IDLE SHALL be ignored.
REQ-022 arready SHALL NOT depend combinationally on arvalid.
REQ-023 Back-to-back accepts SHALL be possible with a minimum spacing of 2 cycles (accept, release, accept).

Reset
REQ-024 While rst=1: state=IDLE, arready=0, addr_good=0, addr=0, prot=0, addr_misaligned=0, timeout=0, and the timeout counter=0.
REQ-025 On the first clock edge after rst falls, arready SHALL rise to 1; no address SHALL be accepted on that edge.
REQ-026 rst asserted in HOLD SHALL abort the transaction immediately (addr_good=0 asynchronously), with no timeout pulse.

Configuration
REQ-027 Macro AXILITE_READ_ADDR_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to HOLD and increment each HOLD cycle; when it reaches TIMEOUT_CYCLES without deassert_addr, the block SHALL pulse timeout=1 for one cycle, set addr_good<=0 and arready<=1, and return to IDLE.
REQ-028 With the macro defined, deassert_addr=1 on the expiry edge SHALL take priority: normal release, no timeout pulse.
REQ-029 Macro undefined: no counter logic; timeout SHALL be tied to 0; HOLD SHALL persist indefinitely until deassert_addr.

Verification
REQ-030 Reset release, then arvalid=1, araddr=0x8 -> arready=1 one cycle after release; handshake; next cycle addr=0x8, addr_good=1, addr_misaligned=0, arready=0.
REQ-031 In HOLD, drive arvalid=1, araddr=0xC for 5 cycles, then deassert_addr=1 -> addr stays 0x8; addr_good=0 and arready=1 one cycle later; 0xC accepted on the following edge.
REQ-032 araddr=0x6 handshake -> addr_misaligned=1 with addr_good=1; it stays 1 after release until the next accept with araddr=0x4 clears it.
REQ-033 With the macro defined and TIMEOUT_CYCLES=4, accept, no deassert_addr -> timeout pulse exactly one cycle wide 4 HOLD cycles after addr_good rises; addr_good=0 and arready=1 afterwards; repeat with deassert_addr on the expiry edge -> no pulse.
REQ-034 rst pulsed mid-HOLD -> addr_good=0 and addr=0 without waiting for clk; arready=1 on the first edge after release.
REQ-035 Without the macro, hold HOLD for 1000 cycles -> timeout stays 0 and addr_good stays 1.

Source files
------------

// File: rtl/axilite_read_addr_if.sv
// AXI-Lite read-address channel plus the latched-address hand-off to the
// read-data stage, bundled so the block and its neighbours share one port.
interface axilite_read_addr_if #(
    parameter int ADDR_SIZE = 32
);
    logic [ADDR_SIZE-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_SIZE-1:0] addr;
    logic [2:0]           prot;
    logic                 addr_good;
    logic                 addr_misaligned;
    logic                 deassert_addr;
    logic                 timeout;

    // The address-capture block itself.
    modport slave (
        input  araddr, arprot, arvalid, deassert_addr,
        output arready, addr, prot, addr_good, addr_misaligned, timeout
    );

    // The bus master together with the read-data stage that consumes addr.
    modport master (
        output araddr, arprot, arvalid, deassert_addr,
        input  arready, addr, prot, addr_good, addr_misaligned, timeout
    );
endinterface

// File: rtl/axilite_read_addr.sv
// AXI-Lite read-address capture: accepts one address at a time, holds it for
// the read-data stage until deassert_addr, then re-opens the channel.
// Optional HOLD watchdog enabled by defining AXILITE_READ_ADDR_TIMEOUT_EN.
module axilite_read_addr #(
    parameter int ADDR_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    axilite_read_addr_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic                 arready_reg;
    logic                 arready_next;
    logic [ADDR_SIZE-1:0] addr_reg;
    logic [2:0]           prot_reg;
    logic                 misaligned_reg;
    logic                 accept;
    logic                 expire;

    // arready_reg is 0 straight out of reset, so the first edge after release
    // only raises arready and never accepts an address.
    assign accept = (state_reg == IDLE) && arready_reg && bus.arvalid;

`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
    // Counter value seen during the last permitted HOLD cycle.
    localparam logic [7:0] EXPIRE_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt_reg;
    logic       timeout_reg;

    // deassert_addr on the expiry edge wins: that is a normal release.
    assign expire = (state_reg == HOLD) && !bus.deassert_addr
                    && (hold_cnt_reg == EXPIRE_COUNT);

    // Count HOLD cycles from zero on each accept; emit a one-cycle pulse on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= expire;
            if (accept) begin
                hold_cnt_reg <= 8'd0;
            end else if (state_reg == HOLD) begin
                hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    // Watchdog absent: HOLD lasts until deassert_addr, however long that takes.
    assign expire             = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State register plus the registered arready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            arready_reg <= arready_next;
        end
    end

    // Next-state decode: accept moves to HOLD, release or expiry back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.deassert_addr || expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        arready_next = (state_next == IDLE);
    end

    // Captured address, protection and alignment flag; held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg       <= '0;
            prot_reg       <= 3'd0;
            misaligned_reg <= 1'b0;
        end else if (accept) begin
            addr_reg       <= bus.araddr;
            prot_reg       <= bus.arprot;
            misaligned_reg <= (bus.araddr[1:0] != 2'b00);
        end
    end

    // Output decode: addr_good follows the state, so reset clears it at once.
    always_comb begin
        bus.arready         = arready_reg;
        bus.addr_good       = (state_reg == HOLD);
        bus.addr            = addr_reg;
        bus.prot            = prot_reg;
        bus.addr_misaligned = misaligned_reg;
`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
        bus.timeout         = timeout_reg;
`else
        bus.timeout         = 1'b0;
`endif
    end

endmodule

// File: tb/tb_axilite_read_addr.sv
// Directed bench for axilite_read_addr: a vector table for the basic
// handshake/hold/release behaviour, then hand-written multi-cycle sequences
// for asynchronous reset and the HOLD watchdog (present or absent).
module tb_axilite_read_addr;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    axilite_read_addr_if #(.ADDR_SIZE(32)) bus ();

    axilite_read_addr #(
        .ADDR_SIZE      (32),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
    axilite_read_addr_if #(.ADDR_SIZE(32)) bus2 ();

    axilite_read_addr #(
        .ADDR_SIZE      (32),
        .TIMEOUT_CYCLES (4)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arvalid;
        logic [31:0] araddr;
        logic [2:0]  arprot;
        logic        deassert;
        logic        exp_arready;
        logic        exp_good;
        logic [31:0] exp_addr;
        logic [2:0]  exp_prot;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic av, input logic [31:0] a, input logic [2:0] p,
                           input logic d, input logic e_rdy, input logic e_good,
                           input logic [31:0] e_addr, input logic [2:0] e_prot, input logic e_mis);
        vecs[i].arvalid     = av;
        vecs[i].araddr      = a;
        vecs[i].arprot      = p;
        vecs[i].deassert    = d;
        vecs[i].exp_arready = e_rdy;
        vecs[i].exp_good    = e_good;
        vecs[i].exp_addr    = e_addr;
        vecs[i].exp_prot    = e_prot;
        vecs[i].exp_mis     = e_mis;
    endtask

`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
    // Accept on the 4-cycle watchdog instance, then either let it expire or
    // release with deassert_addr exactly on the expiry edge.
    task automatic run_timeout(input logic rel_on_expiry);
        @(negedge clk);
        bus2.arvalid = 1'b1;
        bus2.araddr  = 32'h40;
        @(posedge clk); #1;
        check("to_accept_good", 32'(bus2.addr_good), 32'd1);
        $display("[TB] timeout seq rel=%0d accept addr=0x%0h", rel_on_expiry, bus2.addr);
        @(negedge clk);
        bus2.arvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("to_hold%0d_timeout", k), 32'(bus2.timeout), 32'd0);
            check($sformatf("to_hold%0d_good", k), 32'(bus2.addr_good), 32'd1);
        end
        @(negedge clk);
        bus2.deassert_addr = rel_on_expiry;
        @(posedge clk); #1;
        check("to_expiry_timeout", 32'(bus2.timeout), rel_on_expiry ? 32'd0 : 32'd1);
        check("to_expiry_good", 32'(bus2.addr_good), 32'd0);
        check("to_expiry_arready", 32'(bus2.arready), 32'd1);
        $display("[TB] timeout seq rel=%0d expiry timeout=%0d", rel_on_expiry, bus2.timeout);
        @(negedge clk);
        bus2.deassert_addr = 1'b0;
        @(posedge clk); #1;
        check("to_after_timeout", 32'(bus2.timeout), 32'd0);
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //          i  av  araddr  prot dea  rdy good addr   prot mis
        set_vec( 0, 1, 32'h08, 3'd1, 0,   1,  0, 32'h00, 3'd0, 0); // first edge after reset: no accept
        set_vec( 1, 1, 32'h08, 3'd1, 0,   0,  1, 32'h08, 3'd1, 0); // accept 0x8
        set_vec( 2, 1, 32'h0C, 3'd0, 0,   0,  1, 32'h08, 3'd1, 0); // arvalid ignored in HOLD
        set_vec( 3, 1, 32'h0C, 3'd0, 0,   0,  1, 32'h08, 3'd1, 0);
        set_vec( 4, 1, 32'h0C, 3'd0, 0,   0,  1, 32'h08, 3'd1, 0);
        set_vec( 5, 1, 32'h0C, 3'd0, 0,   0,  1, 32'h08, 3'd1, 0);
        set_vec( 6, 1, 32'h0C, 3'd0, 0,   0,  1, 32'h08, 3'd1, 0);
        set_vec( 7, 1, 32'h0C, 3'd3, 1,   1,  0, 32'h08, 3'd1, 0); // release
        set_vec( 8, 1, 32'h0C, 3'd3, 0,   0,  1, 32'h0C, 3'd3, 0); // 0xC accepted
        set_vec( 9, 0, 32'h00, 3'd0, 1,   1,  0, 32'h0C, 3'd3, 0);
        set_vec(10, 1, 32'h06, 3'd5, 0,   0,  1, 32'h06, 3'd5, 1); // misaligned accept
        set_vec(11, 0, 32'h00, 3'd0, 1,   1,  0, 32'h06, 3'd5, 1); // flag retained after release
        set_vec(12, 0, 32'h00, 3'd0, 1,   1,  0, 32'h06, 3'd5, 1); // deassert in IDLE ignored
        set_vec(13, 1, 32'h04, 3'd2, 0,   0,  1, 32'h04, 3'd2, 0); // aligned accept clears flag
        set_vec(14, 1, 32'h10, 3'd7, 1,   1,  0, 32'h04, 3'd2, 0); // release, arvalid ignored
        set_vec(15, 1, 32'h10, 3'd7, 0,   0,  1, 32'h10, 3'd7, 0); // back-to-back accept
        set_vec(16, 0, 32'h00, 3'd0, 1,   1,  0, 32'h10, 3'd7, 0);

        rst               = 1'b1;
        bus.arvalid       = 1'b0;
        bus.araddr        = '0;
        bus.arprot        = '0;
        bus.deassert_addr = 1'b0;
`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
        bus2.arvalid       = 1'b0;
        bus2.araddr        = '0;
        bus2.arprot        = '0;
        bus2.deassert_addr = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_good", 32'(bus.addr_good), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_prot", 32'(bus.prot), 32'd0);
        check("rst_mis", 32'(bus.addr_misaligned), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        $display("[TB] reset: arready=%0d addr_good=%0d addr=0x%0h", bus.arready, bus.addr_good, bus.addr);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            if (i != 0) @(negedge clk);
            bus.arvalid       = vecs[i].arvalid;
            bus.araddr        = vecs[i].araddr;
            bus.arprot        = vecs[i].arprot;
            bus.deassert_addr = vecs[i].deassert;
            @(posedge clk); #1;
            check($sformatf("v%0d_arready", i), 32'(bus.arready), 32'(vecs[i].exp_arready));
            check($sformatf("v%0d_good", i), 32'(bus.addr_good), 32'(vecs[i].exp_good));
            check($sformatf("v%0d_addr", i), bus.addr, vecs[i].exp_addr);
            check($sformatf("v%0d_prot", i), 32'(bus.prot), 32'(vecs[i].exp_prot));
            check($sformatf("v%0d_mis", i), 32'(bus.addr_misaligned), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d_timeout", i), 32'(bus.timeout), 32'd0);
            $display("[TB] vec %0d: arvalid=%0d araddr=0x%0h deassert=%0d -> arready=%0d good=%0d addr=0x%0h mis=%0d",
                     i, vecs[i].arvalid, vecs[i].araddr, vecs[i].deassert,
                     bus.arready, bus.addr_good, bus.addr, bus.addr_misaligned);
        end

        // Asynchronous reset in the middle of a HOLD.
        @(negedge clk);
        bus.arvalid       = 1'b1;
        bus.araddr        = 32'h24;
        bus.deassert_addr = 1'b0;
        @(posedge clk); #1;
        check("ar_accept_good", 32'(bus.addr_good), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_async_good", 32'(bus.addr_good), 32'd0);
        check("ar_async_addr", bus.addr, 32'd0);
        check("ar_async_arready", 32'(bus.arready), 32'd0);
        check("ar_async_timeout", 32'(bus.timeout), 32'd0);
        $display("[TB] mid-HOLD reset: addr_good=%0d addr=0x%0h", bus.addr_good, bus.addr);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ar_release_arready", 32'(bus.arready), 32'd1);
        check("ar_release_good", 32'(bus.addr_good), 32'd0);
        $display("[TB] after reset release: arready=%0d addr_good=%0d", bus.arready, bus.addr_good);
        @(negedge clk);
        bus.arvalid = 1'b0;

`ifdef AXILITE_READ_ADDR_TIMEOUT_EN
        run_timeout(1'b0);
        run_timeout(1'b1);
`else
        begin
            int bad_to;
            int bad_good;
            bad_to   = 0;
            bad_good = 0;
            @(negedge clk);
            bus.arvalid = 1'b1;
            bus.araddr  = 32'h30;
            @(posedge clk); #1;
            check("long_accept_good", 32'(bus.addr_good), 32'd1);
            @(negedge clk);
            bus.arvalid = 1'b0;
            for (int k = 0; k < 1000; k++) begin
                @(posedge clk); #1;
                if (bus.timeout !== 1'b0) bad_to++;
                if (bus.addr_good !== 1'b1) bad_good++;
            end
            check("long_timeout_seen", 32'(bad_to), 32'd0);
            check("long_good_dropped", 32'(bad_good), 32'd0);
            $display("[TB] 1000-cycle hold: timeout cycles=%0d good-low cycles=%0d", bad_to, bad_good);
            @(negedge clk);
            bus.deassert_addr = 1'b1;
            @(posedge clk); #1;
            check("long_release_good", 32'(bus.addr_good), 32'd0);
            check("long_release_arready", 32'(bus.arready), 32'd1);
            $display("[TB] long hold release: arready=%0d addr_good=%0d", bus.arready, bus.addr_good);
            @(negedge clk);
            bus.deassert_addr = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
